// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types, defaults and ROB age compare for the fetch redirect unit
package fetch_pkg;

  localparam int          TAG_W        = 4;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  typedef struct packed {
    logic             wrap;
    logic [TAG_W-1:0] idx;
  } tag_t;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    REDIR = 1'b1
  } fstate_t;

  // A crossed wrap bit means the index order is inverted.
  function automatic logic older(tag_t a, tag_t b);
    if (a.wrap == b.wrap) return a.idx < b.idx;
    else                  return a.idx > b.idx;
  endfunction

endpackage

// File: rtl/tag_age_cmp.sv
// rtl/tag_age_cmp.sv - combinational ROB age compare: a_older is set when tag a precedes tag b
module tag_age_cmp #(
  parameter int TAG_W = fetch_pkg::TAG_W
) (
  input  logic [TAG_W:0] a,
  input  logic [TAG_W:0] b,
  output logic           a_older
);

  always_comb begin
    a_older = 1'b0;
    if (a[TAG_W] == b[TAG_W]) a_older = a[TAG_W-1:0] < b[TAG_W-1:0];
    else                      a_older = a[TAG_W-1:0] > b[TAG_W-1:0];
  end

endmodule

// File: rtl/fetch_redirect_unit.sv
// rtl/fetch_redirect_unit.sv - fetch PC owner, I-cache request driver and oldest-wins redirect/flush arbiter
module fetch_redirect_unit #(
  parameter logic [31:0] RESET_PC = fetch_pkg::RESET_PC_DEF,
  parameter int          TAG_W    = fetch_pkg::TAG_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           br_valid,
  input  logic           br_taken,
  input  logic [31:0]    br_target,
  input  logic [TAG_W:0] br_tag,
  input  logic           xcpt_valid,
  input  logic [31:0]    xcpt_pc,
  input  logic           commit_valid,
  input  logic [TAG_W:0] commit_tag,
  input  logic           fetch_stall,
  output logic           if_req_valid,
  output logic [31:0]    if_req_pc,
  input  logic           if_req_ready,
  output logic           flush_valid,
  output logic           flush_all,
  output logic [TAG_W:0] flush_tag
);
  import fetch_pkg::*;

  logic [31:0]    pc, pc_next;
  logic           rst_q;
  logic           kw_valid, kw_valid_next;
  logic [TAG_W:0] kw_tag, kw_tag_next;
  fstate_t        state, state_next;
  logic           br_older, kw_live, take_br, redirect, accept;

  tag_age_cmp #(.TAG_W(TAG_W)) u_age (
    .a       (br_tag),
    .b       (kw_tag),
    .a_older (br_older)
  );

  assign if_req_valid = !rst_q && !fetch_stall;
  assign if_req_pc    = pc;
  assign accept       = if_req_valid && if_req_ready;

  always_comb begin
    // A retiring kill-window owner frees the window before the new branch is judged.
    kw_live       = kw_valid && !(commit_valid && (commit_tag == kw_tag));
    take_br       = !xcpt_valid && br_valid && br_taken && (!kw_live || br_older);
    redirect      = xcpt_valid || take_br;
    pc_next       = pc;
    kw_valid_next = kw_live;
    kw_tag_next   = kw_tag;
    state_next    = state;

    if (xcpt_valid) begin
      pc_next       = xcpt_pc;
      kw_valid_next = 1'b0;
    end else if (take_br) begin
      pc_next       = br_target;
      kw_valid_next = 1'b1;
      kw_tag_next   = br_tag;
    end else if (accept) begin
      pc_next = pc + 32'd4;
    end

    case (state)
      RUN:     if (redirect) state_next = REDIR;
      REDIR:   if (!redirect && accept) state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      rst_q       <= 1'b1;
      kw_valid    <= 1'b0;
      kw_tag      <= '0;
      state       <= RUN;
      flush_valid <= 1'b0;
      flush_all   <= 1'b0;
      flush_tag   <= '0;
    end else begin
      pc          <= pc_next;
      rst_q       <= 1'b0;
      kw_valid    <= kw_valid_next;
      kw_tag      <= kw_tag_next;
      state       <= state_next;
      flush_valid <= redirect;
      flush_all   <= xcpt_valid;
      if (take_br) flush_tag <= br_tag;
    end
  end

endmodule

// File: doc/fetch_redirect_unit.md
Name: fetch_redirect_unit

Overview:
- Consumes branch-unit resolutions (taken flag, target PC, ROB tag) and commit-time exception redirects.
- Owns the architectural fetch PC register and drives the I-cache request handshake.
- Emits a one-cycle flush to the backend when a taken branch or an exception redirects fetch.
- Arbitrates out-of-order resolutions by ROB age so that the oldest mispredict wins and stale ones are dropped.
- Sits between the execute-stage branch unit and the IF stage; static predict-not-taken.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address after reset
- TAG_W, 4, ROB index width; tags are TAG_W+1 bits (MSB = wrap bit)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- br_valid  in  1  branch unit result valid this cycle
- br_taken  in  1  resolved direction (branch unit Branch output)
- br_target  in  32  resolved target (branch unit Branch_PC)
- br_tag  in  TAG_W+1  ROB tag of the resolving branch
- xcpt_valid  in  1  commit-time redirect (exception/eret)
- xcpt_pc  in  32  commit-time redirect target
- commit_valid  in  1  ROB head retired this cycle
- commit_tag  in  TAG_W+1  tag of the retired entry
- fetch_stall  in  1  decode queue full; suppress requests
- if_req_valid  out  1  I-cache request valid
- if_req_pc  out  32  I-cache request address
- if_req_ready  in  1  I-cache accepts request
- flush_valid  out  1  one-cycle kill pulse
- flush_all  out  1  with flush_valid: kill the entire backend
- flush_tag  out  TAG_W+1  with flush_valid & !flush_all: kill entries younger than flush_tag+1 (the delay slot survives)

Behaviour:
- Reset and clock: one clock (clk); reset rst is synchronous, active-high.
- Reset values:
  - pc = RESET_PC, if_req_valid = 0, flush_valid = 0, flush_all = 0, flush_tag = 0.
  - Kill window is invalid; state is RUN.
- Request handshake:
  - if_req_valid = !rst_q & !fetch_stall, where rst_q is a register set during reset and cleared one cycle after it.
  - if_req_pc = pc.
  - On if_req_valid & if_req_ready and no redirect this cycle: pc <= pc+4 (mod 2^32, wraps 32'hFFFF_FFFC -> 0).
  - While valid & !ready, pc is held stable unless a redirect occurs. A redirect overrides and the I-cache treats the changed address as an abort.
- Age compare, older(a,b):
  - Same wrap bit: a.idx < b.idx.
  - Different wrap bit: a.idx > b.idx.
- Kill window:
  - kw_valid, kw_tag track the oldest branch redirected but not yet retired.
  - Cleared when commit_valid & commit_tag == kw_tag.
- Priority, evaluated combinationally in cycle N; effects registered and visible in N+1:
  1. xcpt_valid:
     - pc <= xcpt_pc.
     - flush_valid = 1, flush_all = 1 in N+1.
     - kw_valid <= 0.
     - A br_valid in the same cycle is dropped.
  2. br_valid & br_taken & (!kw_valid | older(br_tag, kw_tag)):
     - pc <= br_target.
     - flush_valid = 1, flush_all = 0, flush_tag = br_tag in N+1.
     - kw <= {1, br_tag}.
  3. br_valid & br_taken & kw_valid & !older(br_tag, kw_tag):
     - Stale (already killed); no action.
  4. br_valid & !br_taken: no action (predict-not-taken was correct).
- Redirect latency: the target appears on if_req_pc exactly one cycle after resolution, regardless of if_req_ready or fetch_stall.
- flush_valid is a single-cycle pulse. Back-to-back redirects in consecutive cycles give consecutive pulses.
- Commit clears the kill window and a new taken branch arrives in the same cycle: the clear applies first, then rule 2 with kw_valid treated as 0.
- States:
  - RUN: normal sequential fetch.
  - REDIR: entered in the cycle after any redirect; exits to RUN on the first accepted request.
  - While in REDIR, if_req_pc must not advance past the target until it is accepted.
- Reset mid-operation: all state and outputs return to reset values the following cycle; any pending redirect is discarded.

Decomposition:
- Shared package fetch_pkg:
  - TAG_W and the RESET_PC default.
  - Tag struct {wrap, idx}.
  - older() function.
  - State encoding RUN/REDIR.
- One sub-module, tag_age_cmp (a, b -> a_older), is instantiated for the kill-window check; the ROB reuses it.

Test Plan:
1. Reset release, if_req_ready=1 constant -> if_req_pc sequence 0x0, 0x4, 0x8; flush_valid stays 0.
2. br_valid, br_taken=1, br_target=0x0000_0100, br_tag=5'h03 at cycle N -> in N+1: flush_valid=1, flush_all=0, flush_tag=5'h03, if_req_pc=0x100; in N+2 (ready=1): 0x104.
3. Taken br_tag=5'h06, then taken br_tag=5'h04 next cycle -> two flush pulses (tags 06, 04); pc ends at the second target. A subsequent taken br_tag=5'h05 is dropped: no flush, pc unchanged.
4. Wrap compare: kw_tag=5'h1E, taken br_tag=5'h01 (wrapped, younger) -> dropped. Taken br_tag=5'h1C -> accepted.
5. xcpt_valid, xcpt_pc=0x8000_0180 together with taken br_valid, target 0x200 -> N+1: flush_all=1, if_req_pc=0x8000_0180; kill window cleared.
6. if_req_ready=0 for 3 cycles with a redirect in the 2nd cycle -> if_req_pc switches to the target and holds until ready; rst asserted mid-hold -> pc=RESET_PC, if_req_valid=0 next cycle.
